// File: rtl/gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_pkg: shared width, sequencer state encoding and operand helper.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } gcd_seq_state_e;

    // A pair needs the core only when neither operand is zero.
    function automatic logic needs_core(input logic [GCD_W-1:0] a, input logic [GCD_W-1:0] b);
        return (a != '0) && (b != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_sequencer: feeds operand pairs to an external GCD core, returns result. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module gcd_sequencer
    import gcd_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [GCD_W-1:0] op_a,
    input  logic [GCD_W-1:0] op_b,
    output logic             gcd_start,
    output logic [GCD_W-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [GCD_W-1:0] gcd_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [GCD_W-1:0] res_data,
    output logic             res_err
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    gcd_seq_state_e   state_q, state_d;
    logic [GCD_W-1:0] a_q, a_d;
    logic [GCD_W-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GCD_W-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    a_d = op_a;
                    b_d = op_b;
                    if (needs_core(op_a, op_b)) begin
                        state_d = LOAD_A;
                    end else begin
                        // At most one operand is nonzero, so OR yields it (or 0).
                        state_d    = RESP;
                        res_data_d = op_a | op_b;
                        res_err_d  = (op_a == '0) && (op_b == '0);
                    end
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (gcd_done) begin
                    state_d    = RESP;
                    res_data_d = gcd_result;
                    res_err_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = RESP;
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == IDLE);
        res_valid = (state_q == RESP);
        gcd_start = (state_q == LOAD_A);
        gcd_data  = '0;
        if (state_q == LOAD_A) begin
            gcd_data = a_q;
        end else if (state_q == LOAD_B) begin
            gcd_data = b_q;
        end
    end

    assign res_data = res_data_q;
    assign res_err  = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gcd_sequencer: scoreboard bench with a behavioural GCD core responder.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_gcd_sequencer;
    import gcd_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        gcd_start;
    logic [15:0] gcd_data;
    logic        gcd_done = 1'b0;
    logic [15:0] gcd_result = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_err;

    gcd_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .gcd_start(gcd_start), .gcd_data(gcd_data),
        .gcd_done(gcd_done), .gcd_result(gcd_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed { logic [15:0] d; logic e; } exp_t;
    typedef struct packed { logic [15:0] a; logic [15:0] b; } op_t;

    exp_t sbq[$];
    op_t  opq[$];
    int   tests = 0;
    int   fails = 0;
    int   starts = 0;
    int   exp_starts = 0;
    int   bus_err = 0;
    int   last_delay = 0;
    int   ready_mode = 0;
    bit   mute = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a;
        logic [15:0] y = b;
        logic [15:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [15:0] sub_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a;
        logic [15:0] y = b;
        if (x == 0 || y == 0) return x | y;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    // Behavioural GCD core: latches A on start, B next cycle, answers after a random delay.
    int          cstate = 0;
    int          cdelay = 0;
    logic [15:0] ca = '0;
    logic [15:0] cb = '0;
    op_t         ce = '0;
    always @(negedge clk) begin
        gcd_done   = 1'b0;
        gcd_result = 16'($urandom);
        if (!rst_n) begin
            cstate = 0;
        end else begin
            case (cstate)
                0: begin
                    if (gcd_start) begin
                        starts++;
                        ca = gcd_data;
                        if (opq.size() == 0) fail_now("unexpected_start");
                        else begin
                            ce = opq.pop_front();
                            chk("load_a_data", gcd_data, ce.a);
                        end
                        cstate = 1;
                    end else begin
                        if (gcd_data != 0) bus_err++;
                        if ($urandom_range(0, 3) == 0) gcd_done = 1'b1;
                    end
                end
                1: begin
                    chk("load_b_start_low", gcd_start, 0);
                    chk("load_b_data", gcd_data, ce.b);
                    cb         = gcd_data;
                    cdelay     = $urandom_range(0, 8);
                    last_delay = cdelay;
                    cstate     = 2;
                end
                default: begin
                    if (gcd_start || gcd_data != 0) bus_err++;
                    if (res_valid) cstate = 0;
                    else if (!mute) begin
                        if (cdelay == 0) begin
                            gcd_done   = 1'b1;
                            gcd_result = sub_gcd(ca, cb);
                            cstate     = 0;
                        end else begin
                            cdelay--;
                        end
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       res_ready = 1'($urandom_range(0, 1));
            1:       res_ready = 1'b0;
            default: res_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on each result handshake and checks hold stability.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pe = 1'b0;
    logic [15:0] pd = '0;
    exp_t        me;
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            chk("op_ready_in_resp", op_ready, 0);
            if (pv && !pr) begin
                chk("res_data_stable", res_data, pd);
                chk("res_err_stable", res_err, pe);
            end
            if (res_ready) begin
                if (sbq.size() == 0) fail_now("unexpected_result");
                else begin
                    me = sbq.pop_front();
                    chk("res_data", res_data, me.d);
                    chk("res_err", res_err, me.e);
                end
            end
        end
        pv = rst_n && res_valid;
        pr = res_ready;
        pd = res_data;
        pe = res_err;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit wait_res);
        int  n;
        bit  ok;
        exp_t e;
        if (wait_res) begin
            if (a == 0 && b == 0) e = '{d: 16'd0, e: 1'b1};
            else if (a == 0 || b == 0) e = '{d: a | b, e: 1'b0};
            else if (mute) e = '{d: 16'd0, e: 1'b1};
            else e = '{d: ref_gcd(a, b), e: 1'b0};
            sbq.push_back(e);
        end
        if (a != 0 && b != 0) begin
            exp_starts++;
            opq.push_back('{a: a, b: b});
        end
        @(posedge clk); #1;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (op_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            fail_now("op_ready_wait_expired");
            op_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        if (!wait_res) return;
        n  = 0;
        ok = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (res_valid) begin n = i; ok = 1'b1; break; end
        end
        if (!ok) fail_now("res_valid_wait_expired");
        else if (a == 0 || b == 0) chk("bypass_latency", n, 1);
        else if (mute) chk("timeout_latency", n, 19);
        else chk("core_latency", n, 4 + last_delay);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          k;
        repeat (3) @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_gcd_start", gcd_start, 0);
        chk("rst_gcd_data", gcd_data, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_err", res_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(16'd143, 16'd78, 1'b1);
        send(16'd0, 16'd25, 1'b1);
        send(16'd25, 16'd0, 1'b1);
        send(16'd0, 16'd0, 1'b1);

        mute = 1'b1;
        send(16'd9, 16'd6, 1'b1);
        mute = 1'b0;

        ready_mode = 1;
        send(16'd7, 16'd7, 1'b1);
        repeat (10) @(negedge clk);
        chk("held_res_valid", res_valid, 1);
        ready_mode = 0;

        mute = 1'b1;
        send(16'd100, 16'd75, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_wait_no_valid", res_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("async_rst_op_ready", op_ready, 1);
        chk("async_rst_gcd_data", gcd_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mute  = 1'b0;
        @(negedge clk);
        chk("op_ready_after_rst", op_ready, 1);
        send(16'd48, 16'd18, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
            send(ra, rb, 1'b1);
        end

        k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        chk("start_count", starts, exp_starts);
        chk("bus_idle_errors", bus_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
